// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   rep_state_t : auto-repeat FSM states, 2-bit encoding (code 3 unused)
//   max_u       : larger of two unsigned values, sizes the repeat counter
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_HOLD      = 2'd1,
    ST_REPEATING = 2'd2
  } rep_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Debounces one synchronized button level and produces press/release pulses
// plus auto-repeat pulses while the button is held.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   in          : button level, synchronized upstream
//   pressed     : debounced level (1 = held)
//   press       : one-cycle pulse in the first cycle pressed = 1
//   release_evt : one-cycle pulse in the first cycle pressed = 0
//   repeat_evt  : one-cycle auto-repeat pulse
//   step        : press | repeat_evt
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pressed,
  output logic press,
  output logic release_evt,
  output logic repeat_evt,
  output logic step
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RW = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  rep_state_t    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          lvl;
  logic          pressed_d, press_d, release_d, repeat_d, step_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RELEASED;
      dcnt_q      <= '0;
      rcnt_q      <= '0;
      pressed     <= 1'b0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      repeat_evt  <= 1'b0;
      step        <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      rcnt_q      <= rcnt_d;
      pressed     <= pressed_d;
      press       <= press_d;
      release_evt <= release_d;
      repeat_evt  <= repeat_d;
      step        <= step_d;
    end
  end

  // Debounce counter and repeat FSM next-state logic
  always_comb begin
    lvl       = in ^ ACTIVE_LOW;
    dcnt_d    = '0;
    pressed_d = pressed;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    state_d   = state_q;
    rcnt_d    = rcnt_q;

    // Any agreeing sample leaves dcnt_d at 0, restarting the count
    if (lvl != pressed) begin
      if (dcnt_q == DEB_LAST) begin
        pressed_d = lvl;
        press_d   = lvl;
        release_d = ~lvl;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end

    // Release is checked first so it suppresses a coincident repeat
    case (state_q)
      ST_RELEASED: begin
        rcnt_d = '0;
        if (press_d) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (release_d) begin
          state_d = ST_RELEASED;
          rcnt_d  = '0;
        end else if (rcnt_q == HOLD_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
          state_d  = ST_REPEATING;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      ST_REPEATING: begin
        if (release_d) begin
          state_d = ST_RELEASED;
          rcnt_d  = '0;
        end else if (rcnt_q == REP_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        rcnt_d  = '0;
      end
    endcase

    step_d = press_d | repeat_d;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: an active-low and an active-high instance receive the
// same logical button level and are compared each cycle against an
// event-timing reference model.
module tb_button_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 10;
  localparam int unsigned REP  = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_al, in_ah;
  logic al_pressed, al_press, al_release, al_repeat, al_step;
  logic ah_pressed, ah_press, ah_release, ah_repeat, ah_step;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit hist[$];
  bit m_pressed;
  int t;
  int p_time;
  bit e_press, e_release, e_repeat, e_step;

  always #5 clk = ~clk;

  button_conditioner #(
    .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) u_al (
    .clk(clk), .rst(rst), .in(in_al),
    .pressed(al_pressed), .press(al_press), .release_evt(al_release),
    .repeat_evt(al_repeat), .step(al_step)
  );

  button_conditioner #(
    .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) u_ah (
    .clk(clk), .rst(rst), .in(in_ah),
    .pressed(ah_pressed), .press(ah_press), .release_evt(ah_release),
    .repeat_evt(ah_repeat), .step(ah_step)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t cyc=%0d: got %b expected %b", tag, $time, t, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ":al_pressed"}, al_pressed, m_pressed);
    check({ph, ":al_press"},   al_press,   e_press);
    check({ph, ":al_release"}, al_release, e_release);
    check({ph, ":al_repeat"},  al_repeat,  e_repeat);
    check({ph, ":al_step"},    al_step,    e_step);
    check({ph, ":ah_pressed"}, ah_pressed, m_pressed);
    check({ph, ":ah_press"},   ah_press,   e_press);
    check({ph, ":ah_release"}, ah_release, e_release);
    check({ph, ":ah_repeat"},  ah_repeat,  e_repeat);
    check({ph, ":ah_step"},    ah_step,    e_step);
  endtask

  task automatic model_reset();
    hist.delete();
    m_pressed = 1'b0;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_repeat  = 1'b0;
    e_step    = 1'b0;
  endtask

  // Pressed flips once the last DEB samples all disagree with it; repeats
  // fall at press + HOLD + k*REP while still held in that cycle.
  task automatic model_step(input bit lvl);
    bit flip;
    int d;
    t++;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_repeat  = 1'b0;
    hist.push_back(lvl);
    if (hist.size() > DEB) void'(hist.pop_front());
    flip = (hist.size() == DEB);
    foreach (hist[i]) if (hist[i] == m_pressed) flip = 1'b0;
    if (flip) begin
      m_pressed = lvl;
      hist.delete();
      if (lvl) begin
        e_press = 1'b1;
        p_time  = t;
      end else begin
        e_release = 1'b1;
      end
    end
    if (m_pressed && !e_press) begin
      d = t - p_time;
      if (d >= int'(HOLD) && ((d - int'(HOLD)) % int'(REP)) == 0) e_repeat = 1'b1;
    end
    e_step = e_press | e_repeat;
  endtask

  task automatic cycle(input bit lvl, input string ph);
    in_al = ~lvl;
    in_ah = lvl;
    @(posedge clk);
    model_step(lvl);
    #1;
    check_all(ph);
  endtask

  task automatic run(input bit lvl, input int n, input string ph);
    for (int i = 0; i < n; i++) cycle(lvl, ph);
  endtask

  task automatic pulse_reset(input string ph);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    t = 0;
    p_time = 0;
    rst = 1'b1;
    in_al = 1'b1;
    in_ah = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    run(1'b0, 3, "idle");
    run(1'b1, 8, "clean_press");
    run(1'b0, 8, "clean_release");

    run(1'b1, 3, "glitch");
    run(1'b0, 6, "glitch_after");

    run(1'b1, 34, "autorepeat");
    run(1'b0, 6, "autorepeat_rel");

    // Debounced release lands on the edge of the second repeat terminal count
    run(1'b1, 13, "race_hold");
    run(1'b0, 8, "race_rel");

    run(1'b1, 20, "rst_hold");
    pulse_reset("rst_mid");
    run(1'b1, 10, "rst_repress");
    run(1'b0, 8, "rst_release");

    for (int s = 0; s < 80; s++) begin
      int unsigned kind;
      int unsigned len;
      kind = $urandom_range(2, 0);
      case (kind)
        0:       len = $urandom_range(3, 1);
        1:       len = $urandom_range(15, 4);
        default: len = $urandom_range(40, 16);
      endcase
      run(bit'($urandom_range(1, 0)), int'(len), "random");
      if ($urandom_range(19, 0) == 0) pulse_reset("random_rst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
